// File: rtl/corefifo_gray_conv_pipe_if.sv
// Valid/ready stream bundle for the pipelined Gray<->binary converter.
// The slave modport is the converter's view; the master modport drives it.
interface corefifo_gray_conv_pipe_if #(
  parameter int unsigned ADDRWIDTH = 3,
  parameter int unsigned NUM_CH    = 1
) ();
  localparam int unsigned DW = NUM_CH * (ADDRWIDTH + 1);

  logic          in_valid;
  logic          in_ready;
  logic          in_mode;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/corefifo_gray_conv_pipe.sv
// Pipelined multi-channel Gray<->binary pointer converter with valid/ready flow control.
// Define CFIFO_GRAY_CHECK_EN to build the sticky per-channel multi-bit Gray step checker.
module corefifo_gray_conv_pipe #(
  parameter int unsigned ADDRWIDTH   = 3,
  parameter int unsigned NUM_CH      = 1,
  parameter int unsigned PIPE_STAGES = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  corefifo_gray_conv_pipe_if.slave  io,
  input  logic                      chk_clr,
  output logic [NUM_CH-1:0]         chk_err
);
  localparam int unsigned W   = ADDRWIDTH + 1;
  localparam int unsigned DW  = NUM_CH * W;
  localparam int unsigned SEG = (W + PIPE_STAGES - 1) / PIPE_STAGES;

  if (PIPE_STAGES < 1 || PIPE_STAGES > W || NUM_CH < 1 || NUM_CH > 8) begin : g_param_err
    $error("corefifo_gray_conv_pipe: unsupported parameter combination");
  end

  // Stage k resolves the MSB-first segment k of the Gray->binary chain; bin->gray is done in stage 0.
  function automatic logic [DW-1:0] stage_conv(input logic [DW-1:0] x, input logic mode,
                                               input int k);
    logic [DW-1:0] y;
    logic [W-1:0]  ch;
    int            hi;
    int            lo;
    y  = x;
    hi = int'(W) - 1 - k * int'(SEG);
    lo = hi - int'(SEG) + 1;
    if (lo < 0) lo = 0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      ch = x[c*W +: W];
      if (mode) begin
        if (k == 0) ch = ch ^ (ch >> 1);
      end else begin
        for (int i = int'(W) - 2; i >= 0; i--) begin
          if (i <= hi && i >= lo) ch[i] = ch[i+1] ^ ch[i];
        end
      end
      y[c*W +: W] = ch;
    end
    return y;
  endfunction

  logic [PIPE_STAGES-1:0] v;
  logic [PIPE_STAGES-1:0] m;
  logic [DW-1:0]          d  [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] sv;
  logic [PIPE_STAGES-1:0] sm;
  logic [DW-1:0]          sd [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] rdy;
  logic                   accept;

  // Ready ripples back from the output: a stage can load when empty or when it drains this cycle.
  always_comb begin
    logic r;
    rdy = '0;
    r   = io.out_ready;
    for (int k = int'(PIPE_STAGES) - 1; k >= 0; k--) begin
      r      = !v[k] | r;
      rdy[k] = r;
    end
  end

  always_comb begin
    sv    = '0;
    sm    = '0;
    sv[0] = io.in_valid;
    sm[0] = io.in_mode;
    sd[0] = stage_conv(io.in_data, io.in_mode, 0);
    for (int k = 1; k < int'(PIPE_STAGES); k++) begin
      sv[k] = v[k-1];
      sm[k] = m[k-1];
      sd[k] = stage_conv(d[k-1], m[k-1], k);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v <= '0;
      m <= '0;
      for (int k = 0; k < int'(PIPE_STAGES); k++) d[k] <= '0;
    end else begin
      for (int k = 0; k < int'(PIPE_STAGES); k++) begin
        if (rdy[k]) begin
          v[k] <= sv[k];
          if (sv[k]) begin
            d[k] <= sd[k];
            m[k] <= sm[k];
          end
        end
      end
    end
  end

  assign accept       = io.in_valid & rdy[0];
  assign io.in_ready  = rdy[0];
  assign io.out_valid = v[PIPE_STAGES-1];
  assign io.out_data  = d[PIPE_STAGES-1];

  // The last stage's mode has no consumer once the conversion is complete.
  logic unused_last_mode;
  assign unused_last_mode = m[PIPE_STAGES-1];

`ifdef CFIFO_GRAY_CHECK_EN
  function automatic int unsigned popcnt(input logic [W-1:0] x);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(W); i++) n += 32'(x[i]);
    return n;
  endfunction

  logic [DW-1:0]     prev;
  logic [NUM_CH-1:0] primed;
  logic [NUM_CH-1:0] err;
  logic [NUM_CH-1:0] err_set;

  // A legal Gray pointer moves by at most one bit between successive samples.
  always_comb begin
    err_set = '0;
    if (accept && !io.in_mode) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (primed[c] && popcnt(prev[c*W +: W] ^ io.in_data[c*W +: W]) > 1) err_set[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev   <= '0;
      primed <= '0;
      err    <= '0;
    end else begin
      if (accept && !io.in_mode) begin
        prev   <= io.in_data;
        primed <= '1;
      end
      err <= (chk_clr ? '0 : err) | err_set;
    end
  end

  assign chk_err = err;
`else
  logic unused_chk;
  assign unused_chk = chk_clr ^ accept;
  assign chk_err    = '0;
`endif
endmodule

// File: tb/tb_corefifo_gray_conv_pipe.sv
// Directed bench for corefifo_gray_conv_pipe (ADDRWIDTH=3, NUM_CH=2, PIPE_STAGES=2).
// Expected results are hand-computed constants and a Gray lookup table.
module tb_corefifo_gray_conv_pipe;
  localparam int unsigned AW  = 3;
  localparam int unsigned NCH = 2;
  localparam int unsigned PS  = 2;
  localparam int unsigned DW  = NCH * (AW + 1);
`ifdef CFIFO_GRAY_CHECK_EN
  localparam logic [NCH-1:0] ERR_EXP = 2'b01;
`else
  localparam logic [NCH-1:0] ERR_EXP = 2'b00;
`endif

  logic           clk = 1'b0;
  logic           rstn;
  logic           chk_clr;
  logic [NCH-1:0] chk_err;

  corefifo_gray_conv_pipe_if #(.ADDRWIDTH(AW), .NUM_CH(NCH)) io ();

  corefifo_gray_conv_pipe #(.ADDRWIDTH(AW), .NUM_CH(NCH), .PIPE_STAGES(PS)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .io      (io.slave),
    .chk_clr (chk_clr),
    .chk_err (chk_err)
  );

  always #5 clk = ~clk;

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  int unsigned   n_out    = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cur_exp;
  logic          accepted;
  logic          stall_seen;
  logic [3:0]    gtab [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge with inputs set: evaluates both handshakes, then advances one clock.
  task automatic cycle();
    logic [DW-1:0] e;
    #1;
    accepted = 1'b0;
    if (io.in_valid && io.in_ready) begin
      exp_q.push_back(cur_exp);
      accepted = 1'b1;
    end
    if (io.in_valid && !io.in_ready) stall_seen = 1'b1;
    if (io.out_valid && io.out_ready) begin
      n_out++;
      if (exp_q.size() == 0) check("spurious_out", 32'(io.out_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        check("out_data", 32'(io.out_data), 32'(e));
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic mode, input logic [DW-1:0] data, input logic [DW-1:0] exp);
    int n;
    io.in_valid = 1'b1;
    io.in_mode  = mode;
    io.in_data  = data;
    cur_exp     = exp;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!accepted && n < 20);
    check("send_accept", 32'(accepted), 32'd1);
  endtask

  task automatic drain();
    io.in_valid = 1'b0;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) cycle();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    io.in_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int          i;
    int unsigned n_before;
    gtab = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4};
    rstn = 1'b0; chk_clr = 1'b0;
    io.in_valid = 1'b0; io.in_mode = 1'b0; io.in_data = '0; io.out_ready = 1'b1;
    cur_exp = '0; accepted = 1'b0; stall_seen = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(io.out_valid), 32'd0);
    check("rst_out_data", 32'(io.out_data), 32'd0);
    check("rst_chk_err", 32'(chk_err), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(io.in_ready), 32'd1);

    // 1: Gray->bin, exact two-cycle latency, single output pulse
    io.in_valid = 1'b1; io.in_mode = 1'b0; io.in_data = 8'b0001_1101; cur_exp = 8'b0001_1001;
    cycle();
    io.in_valid = 1'b0;
    check("t1_lat1_valid", 32'(io.out_valid), 32'd0);
    cycle();
    check("t1_lat2_valid", 32'(io.out_valid), 32'd1);
    check("t1_data", 32'(io.out_data), 32'b0001_1001);
    cycle();
    check("t1_pulse", 32'(io.out_valid), 32'd0);

    // 2: bin->gray, then alternating modes back-to-back
    send(1'b1, 8'b1111_1001, 8'b1000_1101);
    send(1'b0, 8'b0011_0110, 8'b0010_0100);
    send(1'b1, 8'b0011_0110, 8'b0010_0101);
    send(1'b0, 8'b0001_1101, 8'b0001_1001);
    drain();

    // 3: streaming with output stalled for cycles 3..5
    stall_seen = 1'b0; n_before = n_out; i = 0;
    for (int cyc = 0; cyc < 60 && (i < 8 || exp_q.size() != 0); cyc++) begin
      io.out_ready = !(cyc >= 3 && cyc <= 5);
      if (i < 8) begin
        io.in_valid = 1'b1; io.in_mode = 1'b1;
        io.in_data  = {4'(i), 4'(i)};
        cur_exp     = {gtab[i], gtab[i]};
      end else io.in_valid = 1'b0;
      cycle();
      if (accepted) i++;
    end
    io.in_valid = 1'b0; io.out_ready = 1'b1;
    check("t3_stall_seen", 32'(stall_seen), 32'd1);
    check("t3_accepted", 32'(i), 32'd8);
    check("t3_delivered", n_out - n_before, 32'd8);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // 4: pointer wrap codes, single-bit Gray steps
    do_reset();
    send(1'b0, 8'b0000_1000, 8'b0000_1111);
    send(1'b0, 8'b0000_0000, 8'b0000_0000);
    drain();
    check("t4_chk_err", 32'(chk_err), 32'd0);

    // 5: multi-bit Gray step on ch0, clear, and error winning over a coincident clear
    do_reset();
    send(1'b0, 8'b0000_0000, 8'b0000_0000);
    check("t5_err_first", 32'(chk_err), 32'd0);
    send(1'b0, 8'b0000_0011, 8'b0000_0010);
    io.in_valid = 1'b0;
    check("t5_err_set", 32'(chk_err), 32'(ERR_EXP));
    chk_clr = 1'b1;
    cycle();
    chk_clr = 1'b0;
    check("t5_err_clr", 32'(chk_err), 32'd0);
    chk_clr = 1'b1;
    send(1'b0, 8'b0000_1100, 8'b0000_1000);
    chk_clr = 1'b0; io.in_valid = 1'b0;
    check("t5_err_prio", 32'(chk_err), 32'(ERR_EXP));
    drain();

    // 6: asynchronous reset with two items in flight
    send(1'b1, 8'h12, 8'h13);
    send(1'b1, 8'h34, 8'h26);
    io.in_valid = 1'b0;
    check("t6_prefill_valid", 32'(io.out_valid), 32'd1);
    rstn = 1'b0;
    #1;
    check("t6_async_valid", 32'(io.out_valid), 32'd0);
    check("t6_async_err", 32'(chk_err), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    n_before = n_out;
    repeat (4) cycle();
    check("t6_no_stale", n_out - n_before, 32'd0);
    check("t6_post_valid", 32'(io.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
